// File: rtl/clfsr_decrypt_if.sv
// rtl/clfsr_decrypt_if.sv - Encrypted-in / decrypted-out pixel handshake bundle.
interface clfsr_decrypt_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_r;
  logic [7:0] out_g;
  logic [7:0] out_b;

  modport slave (
    input  in_valid, in_r, in_g, in_b, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b
  );

  modport master (
    output in_valid, in_r, in_g, in_b, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b
  );
endinterface

// File: rtl/clfsr_decrypt.sv
// rtl/clfsr_decrypt.sv - Chaotic-LFSR pixel decryptor: regenerates the keystream
// from the shared seed and XORs it off one accepted pixel at a time.
module clfsr_decrypt #(
  parameter int          NPIX     = 65536,
  parameter logic [31:0] SEED_RST = 32'hACE1_2024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    seed_in,
  input  logic           seed_load,
  input  logic           start,
  clfsr_decrypt_if.slave px,
  output logic           busy,
  output logic           done,
  output logic [16:0]    pix_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  localparam logic [16:0] NPIX_C = 17'(NPIX);

  state_e      state_q, state_d;
  logic [31:0] s_q, s_d;
  logic [31:0] seed_q, seed_d;
  logic [16:0] pix_cnt_q, pix_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_r_q, out_r_d;
  logic [7:0]  out_g_q, out_g_d;
  logic [7:0]  out_b_q, out_b_d;
  logic        accept;
  logic [31:0] seed_new;
  logic [31:0] s_step;
  logic [31:0] s_pert;

  // The all-zero word is a lock-up state for the LFSR, so it is never stored.
  function automatic logic [31:0] nonzero(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  assign px.in_ready = (state_q == RUN) && (!out_valid_q || px.out_ready);
  assign accept      = px.in_valid && px.in_ready;
  assign seed_new    = nonzero(seed_in);
  assign s_step      = {s_q[30:0], s_q[31] ^ s_q[21] ^ s_q[1] ^ s_q[0]};
  assign s_pert      = nonzero(s_step ^ {seed_q[15:0], seed_q[31:16]});

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    seed_d      = seed_q;
    pix_cnt_d   = pix_cnt_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_g_d     = out_g_q;
    out_b_d     = out_b_q;

    if (px.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Key is taken from the state before the step; every 256th pixel is perturbed.
    if (accept) begin
      out_valid_d = 1'b1;
      out_r_d     = px.in_r ^ s_q[7:0];
      out_g_d     = px.in_g ^ s_q[15:8];
      out_b_d     = px.in_b ^ s_q[23:16];
      s_d         = (pix_cnt_q[7:0] == 8'hFF) ? s_pert : s_step;
      pix_cnt_d   = pix_cnt_q + 17'd1;
    end

    case (state_q)
      IDLE: begin
        if (seed_load) begin
          seed_d = seed_new;
        end
        if (start) begin
          s_d       = seed_load ? seed_new : seed_q;
          pix_cnt_d = 17'd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (accept && (pix_cnt_d == NPIX_C)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!out_valid_q || px.out_ready) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      s_q         <= 32'd0;
      seed_q      <= SEED_RST;
      pix_cnt_q   <= 17'd0;
      out_valid_q <= 1'b0;
      out_r_q     <= 8'd0;
      out_g_q     <= 8'd0;
      out_b_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_q      <= seed_d;
      pix_cnt_q   <= pix_cnt_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_g_q     <= out_g_d;
      out_b_q     <= out_b_d;
    end
  end

  assign px.out_valid = out_valid_q;
  assign px.out_r     = out_r_q;
  assign px.out_g     = out_g_q;
  assign px.out_b     = out_b_q;
  assign busy         = (state_q == RUN) || (state_q == FLUSH);
  assign done         = (state_q == DONE);
  assign pix_cnt      = pix_cnt_q;
endmodule
